pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL provide parameter MULT_LAT, default 5: mult/multu busy cycles.
REQ-002 SHALL provide parameter DIV_LAT, default 10: div/divu busy cycles.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port id_valid  input  1  ID stage holds a real instruction.
REQ-006 SHALL have ports id_rs, id_rt  input  5 each  ID source register numbers.
REQ-007 SHALL have ports id_use_rs, id_use_rt  input  1 each  source is read.
REQ-008 SHALL have port id_dst  input  5  ID destination register; 0 = none.
REQ-009 SHALL have port id_load  input  1  ID instruction is lw.
REQ-010 SHALL have port id_branch  input  1  ID is beq/bne, compared in ID.
REQ-011 SHALL have port id_jump  input  1  ID is j/jal/jr.
REQ-012 SHALL have port id_md  input  2  00 none, 01 mult start, 10 div start, 11 mfhi/mflo.
REQ-013 SHALL have port br_taken  input  1  ID branch-compare result.
REQ-014 SHALL have port pc_write  output  1  PC may load next value.
REQ-015 SHALL have port ifid_write  output  1  IF/ID register may load.
REQ-016 SHALL have port pc_redirect  output  1  PC selects branch/jump target.
REQ-017 SHALL have port ifid_flush  output  1  IF/ID loads a bubble.
REQ-018 SHALL have port idex_bubble  output  1  ID/EX loads a bubble.
REQ-019 SHALL have port stall_cnt  output  16  saturating stall-cycle counter.

Function
REQ-020 SHALL keep internal shadow scoreboard EX {dst, load} and MEM {dst, load}, each cycle MEM <= EX, EX <= ID fields if ID advances, else bubble (dst 0).
REQ-021 SHALL treat register 0 as never hazardous.
REQ-022 SHALL raise load-use hazard when EX.load and EX.dst matches a used ID source.
REQ-023 SHALL raise branch hazard when id_branch or jr-jump and a used source matches EX.dst (any) or MEM.dst with MEM.load.
REQ-024 SHALL keep md_cnt (4 bits min): on ID advance with id_md 01 load MULT_LAT, 10 load DIV_LAT; else decrement to 0.
REQ-025 SHALL raise md hazard when id_md != 00 and md_cnt != 0.
REQ-026 SHALL, on any hazard with id_valid: pc_write=0, ifid_write=0, idex_bubble=1, pc_redirect=0, ifid_flush=0.
REQ-027 SHALL, with no hazard and id_valid and (id_jump or id_branch&br_taken): pc_redirect=1, ifid_flush=1, pc_write=1.
REQ-028 SHALL otherwise drive pc_write=1, ifid_write=1, others 0; all outputs combinational from state and inputs.
REQ-029 SHALL run FSM RUN/HAZ/MDW: next HAZ on data hazard, MDW on md hazard (md has priority), else RUN; state visible only through stall_cnt.
REQ-030 SHALL increment stall_cnt each cycle state is HAZ or MDW, saturating at 0xFFFF.
REQ-031 SHALL ignore br_taken while stalled; branch resolves on first non-stalled cycle.

Reset
REQ-032 SHALL on reset clear scoreboard, md_cnt, stall_cnt to 0 and state to RUN, overriding all inputs that cycle.
REQ-033 SHALL, while reset high, drive pc_write=1, ifid_write=1, other outputs 0.

Structure
REQ-034 SHALL put id_md encodings, FSM state encodings, and default latencies in shared package pipe_ctrl_pkg.
REQ-035 SHALL implement md_cnt as sub-module md_busy_cnt (load, decrement, zero flag).

Verification
REQ-036 lw $8 then add $9,$8,$8 -> exactly 1 cycle pc_write=0, idex_bubble=1; stall_cnt=1.
REQ-037 add $8 then beq $8,$0 taken -> 1 stall, then pc_redirect=1, ifid_flush=1 for 1 cycle.
REQ-038 lw $8 then beq $8,$9 -> 2 stall cycles, stall_cnt=2.
REQ-039 div then mflo next cycle -> 10 stall cycles (DIV_LAT), mflo advances on 11th.
REQ-040 lw $0 then add $9,$0,$0 -> no stall; reset asserted mid-div stall -> next cycle RUN, stall_cnt=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline hazard controller.
// Holds multiply/divide opcodes, controller state names, latencies and small helpers.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MULT = 2'b01,
    MD_DIV  = 2'b10,
    MD_MFHL = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_RUN = 2'b00,
    ST_HAZ = 2'b01,
    ST_MDW = 2'b10
  } hz_state_e;

  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;

  // One shadow pipeline slot: destination register and whether it is a load.
  typedef struct packed {
    logic [4:0] dst;
    logic       load;
  } sb_entry_t;

  // Busy counter must hold the largest latency and never be narrower than 4 bits.
  function automatic int cnt_width(input int max_lat);
    int w;
    w = $clog2(max_lat + 1);
    return (w < 4) ? 4 : w;
  endfunction

  // Register 0 is hardwired to zero, so it can never create a dependency.
  function automatic logic src_hit(input logic [4:0] src, input logic used,
                                   input logic [4:0] dst);
    return used && (src != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Multiply/divide unit busy counter: loads a latency, counts down to zero.
// The zero flag tells the hazard logic the HI/LO results are ready.
module md_busy_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for a 5-stage MIPS-style pipeline with ID-stage branches.
// Tracks EX/MEM destinations in a shadow scoreboard plus a mult/div busy counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  id_dst,
  input  logic        id_load,
  input  logic        id_branch,
  input  logic        id_jump,
  input  logic [1:0]  id_md,
  input  logic        br_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        pc_redirect,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [15:0] stall_cnt
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = cnt_width(MAX_LAT);

  hz_state_e state_q, state_d;
  sb_entry_t ex_q, mem_q;
  md_op_e    md_op;
  logic      md_zero;
  logic      ex_hit, mem_hit, load_use, br_haz;
  logic      data_haz, md_haz, stall, advance;
  logic      md_load;
  logic [CNT_W-1:0] md_lat;

  assign md_op = md_op_e'(id_md);

  assign ex_hit  = src_hit(id_rs, id_use_rs, ex_q.dst)  | src_hit(id_rt, id_use_rt, ex_q.dst);
  assign mem_hit = src_hit(id_rs, id_use_rs, mem_q.dst) | src_hit(id_rt, id_use_rt, mem_q.dst);

  // j/jal read no sources, so only jr can actually match here.
  assign load_use = ex_q.load & ex_hit;
  assign br_haz   = (id_branch | id_jump) & (ex_hit | (mem_q.load & mem_hit));

  assign data_haz = id_valid & (load_use | br_haz);
  assign md_haz   = id_valid & (md_op != MD_NONE) & ~md_zero;
  assign stall    = data_haz | md_haz;
  assign advance  = id_valid & ~stall;

  assign md_load = advance & ((md_op == MD_MULT) | (md_op == MD_DIV));
  assign md_lat  = (md_op == MD_DIV) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

  md_busy_cnt #(.W(CNT_W)) u_md_busy (
    .clk      (clk),
    .reset    (reset),
    .load     (md_load),
    .load_val (md_lat),
    .zero     (md_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      ex_q      <= '0;
      mem_q     <= '0;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= ex_q;
      ex_q    <= advance ? '{dst: id_dst, load: id_load} : '0;
      if ((state_q != ST_RUN) && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  // On a redirect IF/ID still loads, but the flush turns that load into a bubble.
  always_comb begin
    state_d     = ST_RUN;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    pc_redirect = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!reset) begin
      if (md_haz) begin
        state_d = ST_MDW;
      end else if (data_haz) begin
        state_d = ST_HAZ;
      end
      if (stall) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end else if (id_valid && (id_jump || (id_branch && br_taken))) begin
        pc_redirect = 1'b1;
        ifid_flush  = 1'b1;
      end
    end
  end

endmodule
